// File: rtl/gamma_op_scheduler.sv
// gamma_op_scheduler: time-multiplexes one shared race-logic operator among
// NUM_REQ requesters, one operand pair per gamma cycle.
// Each gamma cycle picks a requester round-robin, pulses the operator set,
// drives rising-edge operand lines, timestamps the first op_y edge and
// returns the result on a valid/ready channel.
// Ports:
//   aclk, grst            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot, IDLE only)
//   req_ta/req_tb         packed operand edge times, requester i at [i*TIME_W +: TIME_W]
//   op_set/op_a/op_b/op_y operator set pulse, operand lines, operator output
//   gamma_start, busy     gamma-cycle strobe, non-IDLE indicator
//   rsp_*                 result channel: requester id, first-edge time, fired flag
module gamma_op_scheduler #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned TIME_W            = 5
) (
    input  logic                          aclk,
    input  logic                          grst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*TIME_W-1:0]     req_ta,
    input  logic [NUM_REQ*TIME_W-1:0]     req_tb,
    output logic                          op_set,
    output logic                          op_a,
    output logic                          op_b,
    input  logic                          op_y,
    output logic                          gamma_start,
    output logic                          busy,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [TIME_W-1:0]             rsp_ty,
    output logic                          rsp_fired
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam logic [TIME_W-1:0] T_LAST = TIME_W'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SET    = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [TIME_W-1:0]   ta_q, ta_d, tb_q, tb_d;
    logic [TIME_W-1:0]   t_q, t_d, ty_q, ty_d;
    logic [ID_W-1:0]     id_q, id_d, last_q, last_d;
    logic                fired_q, fired_d;
    logic                op_a_q, op_a_d, op_b_q, op_b_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;
    logic [TIME_W-1:0]   sel_ta, sel_tb, t_inc;

    // Round-robin search starting one past the last granted requester.
    always_comb begin : rr_grant
        int unsigned     cand;
        logic [ID_W-1:0] cand_id;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_id     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_found && !grst;
    assign sel_ta = req_ta[32'(grant_idx)*TIME_W +: TIME_W];
    assign sel_tb = req_tb[32'(grant_idx)*TIME_W +: TIME_W];
    assign t_inc  = t_q + TIME_W'(1);

    // State register.
    always_ff @(posedge aclk) begin
        if (grst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SET;
            S_SET:    state_d = S_RUN;
            S_RUN:    if (t_q == T_LAST) state_d = S_REPORT;
            S_REPORT: if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; req_ready stays low while grst is asserted.
    always_comb begin
        req_ready   = '0;
        op_set      = 1'b0;
        gamma_start = 1'b0;
        busy        = 1'b1;
        rsp_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) req_ready[grant_idx] = 1'b1;
            end
            S_SET: begin
                op_set      = 1'b1;
                gamma_start = 1'b1;
            end
            S_REPORT: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values. Operand lines are registered one cycle ahead so
    // they equal (t >= time) for the t held in t_q, with no decode glitches.
    // Times >= GAMMA_CYCLE_WIDTH never compare true because t stops at T_LAST.
    always_comb begin
        ta_d    = ta_q;
        tb_d    = tb_q;
        id_d    = id_q;
        last_d  = last_q;
        t_d     = t_q;
        fired_d = fired_q;
        ty_d    = ty_q;
        op_a_d  = 1'b0;
        op_b_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ta_d   = sel_ta;
                    tb_d   = sel_tb;
                    id_d   = grant_idx;
                    last_d = grant_idx;
                end
            end
            S_SET: begin
                t_d     = '0;
                fired_d = 1'b0;
                ty_d    = '1;
                op_a_d  = (ta_q == '0);
                op_b_d  = (tb_q == '0);
            end
            S_RUN: begin
                if (op_y && !fired_q) begin
                    fired_d = 1'b1;
                    ty_d    = t_q;
                end
                if (t_q != T_LAST) begin
                    t_d    = t_inc;
                    op_a_d = (t_inc >= ta_q);
                    op_b_d = (t_inc >= tb_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge aclk) begin
        if (grst) begin
            ta_q    <= '0;
            tb_q    <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            t_q     <= '0;
            fired_q <= 1'b0;
            ty_q    <= '0;
            op_a_q  <= 1'b0;
            op_b_q  <= 1'b0;
        end else begin
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            id_q    <= id_d;
            last_q  <= last_d;
            t_q     <= t_d;
            fired_q <= fired_d;
            ty_q    <= ty_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rsp_id    = id_q;
    assign rsp_ty    = ty_q;
    assign rsp_fired = fired_q;

endmodule

// File: tb/tb_gamma_op_scheduler.sv
// Directed bench for gamma_op_scheduler with a behavioural inequality
// operator (y = a xor b: high from min(ta,tb) when the times differ).
module tb_gamma_op_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned G  = 16;
    localparam int unsigned TW = 5;

    logic              aclk;
    logic              grst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*TW-1:0]   req_ta;
    logic [N*TW-1:0]   req_tb;
    logic              op_set, op_a, op_b, op_y;
    logic              gamma_start, busy;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [TW-1:0]     rsp_ty;
    logic              rsp_fired;

    int total = 0;
    int bad   = 0;

    gamma_op_scheduler #(
        .NUM_REQ(N), .GAMMA_CYCLE_WIDTH(G), .TIME_W(TW)
    ) dut (
        .aclk(aclk), .grst(grst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ta(req_ta), .req_tb(req_tb),
        .op_set(op_set), .op_a(op_a), .op_b(op_b), .op_y(op_y),
        .gamma_start(gamma_start), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_ty(rsp_ty), .rsp_fired(rsp_fired)
    );

    assign op_y = op_a ^ op_b;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge aclk);
        #1;
    endtask

    // One full operation for requester idx; optional response backpressure.
    task automatic run_op(input int idx, input int ta, input int tb,
                          input int exp_ty, input int exp_fired, input int bp);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_ta[idx*TW +: TW] = TW'(ta);
        req_tb[idx*TW +: TW] = TW'(tb);
        #1;
        chk("accept_ready", 32'(req_ready), 32'(1 << idx));
        chk("accept_busy", 32'(busy), 0);
        next_cyc();
        req_valid = '0;
        chk("set_op_set", 32'(op_set), 1);
        chk("set_gamma_start", 32'(gamma_start), 1);
        chk("set_op_a", 32'(op_a), 0);
        chk("set_ready", 32'(req_ready), 0);
        for (int t = 0; t < int'(G); t++) begin
            next_cyc();
            chk("run_op_a", 32'(op_a), 32'(t >= ta));
            chk("run_op_b", 32'(op_b), 32'(t >= tb));
            chk("run_op_set", 32'(op_set), 0);
        end
        next_cyc();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(idx));
        chk("rsp_ty", 32'(rsp_ty), 32'(exp_ty));
        chk("rsp_fired", 32'(rsp_fired), 32'(exp_fired));
        if (bp > 0) begin
            req_valid = '1;
            for (int c = 0; c < bp; c++) begin
                next_cyc();
                chk("bp_rsp_valid", 32'(rsp_valid), 1);
                chk("bp_rsp_id", 32'(rsp_id), 32'(idx));
                chk("bp_rsp_ty", 32'(rsp_ty), 32'(exp_ty));
                chk("bp_rsp_fired", 32'(rsp_fired), 32'(exp_fired));
                chk("bp_req_ready", 32'(req_ready), 0);
                chk("bp_op_lines", 32'({op_a, op_b, op_set}), 0);
            end
            req_valid = '0;
        end
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1;
        rsp_ready = 1'b0;
        next_cyc();
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_busy", 32'(busy), 0);
    endtask

    initial begin
        int opc;
        grst      = 1'b1;
        req_valid = '0;
        req_ta    = '0;
        req_tb    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge aclk);
        next_cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({op_set, op_a, op_b, gamma_start, rsp_valid, rsp_fired}), 0);
        chk("rst_rsp", 32'({rsp_id, rsp_ty}), 0);
        chk("rst_ready", 32'(req_ready), 0);
        grst = 1'b0;
        next_cyc();

        // Fairness: all valid, rsp_ready held -> 0,1,2,3,0,1 at one op per G+3 cycles.
        for (int i = 0; i < int'(N); i++) begin
            req_ta[i*TW +: TW] = TW'(1);
            req_tb[i*TW +: TW] = TW'(4);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        opc = 0;
        #1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < int'(G) + 3; c++) begin
                chk("fair_onehot", 32'($countones(req_ready) <= 1), 1);
                opc += int'(op_set);
                if (c == 0) chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
                if (c == 1) chk("fair_op_set", 32'(op_set), 1);
                if (c == int'(G) + 2) begin
                    chk("fair_rsp_valid", 32'(rsp_valid), 1);
                    chk("fair_rsp_id", 32'(rsp_id), 32'(k % 4));
                    chk("fair_rsp_ty", 32'(rsp_ty), 1);
                end
                next_cyc();
            end
        end
        chk("fair_op_set_count", 32'(opc), 6);
        chk("fair_next_grant", 32'(req_ready), 32'(1 << 2));
        req_valid = '0;
        rsp_ready = 1'b0;
        next_cyc();

        run_op(0, 3, 7, 3, 1, 0);        // single request
        run_op(2, 5, 5, 5'h1F, 0, 0);    // equal times: never fires
        run_op(1, 16, 2, 2, 1, 0);       // ta beyond window: op_a stays low
        run_op(3, 9, 4, 4, 1, 10);       // response backpressure
        run_op(0, 0, 6, 0, 1, 0);        // ta=0: op_a high from first RUN cycle

        // Reset in the middle of RUN.
        req_valid = 4'b0001;
        req_ta[0 +: TW] = TW'(2);
        req_tb[0 +: TW] = TW'(12);
        #1;
        chk("mid_accept", 32'(req_ready), 1);
        next_cyc();
        req_valid = '0;
        repeat (9) next_cyc();
        chk("mid_t8_op_a", 32'(op_a), 1);
        chk("mid_t8_busy", 32'(busy), 1);
        grst = 1'b1;
        next_cyc();
        req_valid = 4'b0110;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_outs", 32'({op_set, op_a, op_b, gamma_start, rsp_valid}), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        next_cyc();
        chk("mid_rst_no_rsp", 32'(rsp_valid), 0);
        grst = 1'b0;
        #1;
        chk("mid_rel_grant", 32'(req_ready), 32'(4'b0010));
        next_cyc();
        chk("mid_rel_op_set", 32'(op_set), 1);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
